dem_ms_shaper: RTL
==================

# dem_ms_shaper

Parametrised N-element dynamic-element-matching encoder for the DAC digital back-end. It takes an unsigned selection count per sample and produces an N-bit unit-element select vector. The mismatch-shaping loop is first or second order, set by parameter. Element selection is done iteratively, one element per clock, behind a valid/ready handshake, so the same block serves any element count without an N-wide sorter. It sits between the noise-shaping modulator output and the unit-element driver register, and supersedes the fixed 18-element combinational selector.

## Interface
- N, 18: number of unit elements (4..64).
- W, 10: signed integrator width per element.
- ORDER, 2: mismatch-shaping loop order (1 or 2).
- ISI_W, 4: transition-shaping weight, used only under DEM_ISI_EN.
- VW, $clog2(N+1): width of v (derived; not overridden).
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  v/mode valid.
- in_ready  out  1  block idle, accepting a sample.
- v  in  VW  unsigned element count, 0..N.
- mode  in  2  00 shaping, 01 rotate (DWA), 10 thermometer, 11 same as 10.
- out_valid  out  1  one-cycle strobe, sv/st updated.
- sv  out  N  element select vector, held between strobes.
- st  out  N  transition vector, sv XOR previous sv.
- sat  out  1  high with out_valid if any integrator clipped, or v>N, in this sample.

## Operation
- FSM states: IDLE, SEARCH, UPDATE. in_ready is 1 only in IDLE.
- IDLE: on in_valid & in_ready, latch v and mode, clear the selection mask, and set cnt=0.
  - Clamp v>N to N and flag sat.
  - Next state is SEARCH if mode=00 and v>0; otherwise UPDATE.
- Key per element:
  - ORDER=1: k[i]=s1[i].
  - ORDER=2: k[i]=s1[i]+s2[i], computed at W+1 bits.
- SEARCH:
  - Each cycle, mask the unmasked element with the smallest k[i]. Ties go to the lowest index.
  - Increment cnt. When cnt reaches v, go to UPDATE.
- UPDATE, mode 00:
  - sv = mask.
  - y[i] = sv[i]*N - v (signed, W+1 bits).
  - s1[i] += y[i], then s2[i] += new s1[i].
  - Both saturate to the signed W range; any clip sets sat.
- UPDATE, mode 01:
  - sv = v consecutive bits starting at ptr, wrapping at N.
  - ptr = (ptr+v) mod N.
  - Integrators hold.
- UPDATE, modes 10/11:
  - sv = lowest v bits set.
  - Integrators and ptr hold.
- UPDATE, all modes: st = sv ^ sv_prev, sv_prev = sv, pulse out_valid, return to IDLE.
- In shaping mode, the sum of y over all elements is 0 every sample, so Σs1 = Σs2 = 0 unless saturation occurs.

## Timing
- Reset values:
  - Outputs: in_ready=1, out_valid=0, sv=0, st=0, sat=0.
  - Internal: s1=s2=0, ptr=0, sv_prev=0, state IDLE.
- Latency from accepting edge to out_valid:
  - Mode 00 with v≥1: v+2 cycles.
  - v=0, mode 01, modes 10/11: 2 cycles.
- in_ready rises in the same cycle out_valid is high. A sample presented then is accepted at the next edge.
- Maximum throughput is one sample per N+2 cycles.
- in_valid while busy is ignored; the source must hold it. mode and v changes while busy have no effect on the sample in flight.
- v=N: all elements are selected; y=N-N=0 for every element, so the integrators are unchanged.
- DWA wrap: ptr stays in 0..N-1. v=N leaves ptr unchanged.
- rstn low mid-SEARCH aborts immediately: mask, integrators and outputs return to reset values, and no out_valid is emitted.

## Configuration
- DEM_ISI_EN defined:
  - Shaping-mode key adds -ISI_W if sv_prev[i]=1 and +ISI_W otherwise. This favours keeping elements in their previous state, which lowers transition density.
  - The key is computed at W+2 bits.
- DEM_ISI_EN undefined: key is as in Operation; no transition term is built.
- st is produced in both cases.

## Test plan
- N=18, ORDER=1, mode 00, no ISI; from reset send v=9 twice:
  - First sample: sv=0x001FF.
  - Second sample: sv=0x3FE00, st=0x3FFFF.
  - Each out_valid arrives 11 cycles after acceptance.
- Mode 10, v=5 → sv=0x0001F at 2-cycle latency; integrators unchanged, checked by a following mode-00 v=9 giving sv=0x001FF.
- Mode 01, v=16 then v=4 → second sample sv has bits 16,17,0,1 set (0x30003); ptr ends at 2.
- v=20 with N=18 → sv all ones, sat=1 with out_valid; integrators unchanged.
- ORDER=2, 1000 random v in 0..18, mode 00:
  - Σs1 and Σs2 are 0 after every sample.
  - Popcount of sv equals v.
  - in_ready is low exactly v+1 cycles per sample.
- rstn asserted in SEARCH cycle 3 of v=9 → outputs zero immediately, no out_valid; the next sample behaves as from reset. With DEM_ISI_EN, repeated v=9 holds sv at 0x001FF while the integrator gap is ≤2·ISI_W.

Source files
------------

// File: rtl/dem_ms_shaper.sv
// dem_ms_shaper: iterative N-element dynamic-element-matching encoder (shaping, DWA, thermometer).
// Define DEM_ISI_EN to add the transition-shaping term to the shaping-mode selection key.
module dem_ms_shaper #(
  parameter int N     = 18,
  parameter int W     = 10,
  parameter int ORDER = 2,
  parameter int ISI_W = 4,
  localparam int VW   = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [VW-1:0] v,
  input  logic [1:0]    mode,
  output logic          out_valid,
  output logic [N-1:0]  sv,
  output logic [N-1:0]  st,
  output logic          sat
);
  localparam int PW = $clog2(N);
`ifdef DEM_ISI_EN
  localparam int KW = W + 2;
`else
  localparam int KW = W + 1;
`endif
  localparam int YW = W + 1;
  localparam int AW = W + 2;
  localparam logic signed [AW-1:0] SMAX = AW'((2 ** (W - 1)) - 1);
  localparam logic signed [AW-1:0] SMIN = AW'(-(2 ** (W - 1)));

  typedef enum logic [1:0] {IDLE, SEARCH, UPDATE} state_t;

  state_t              state, next_state;
  logic [VW-1:0]       v_lat, cnt;
  logic [1:0]          mode_lat;
  logic                sat_lat;
  logic [N-1:0]        mask;
  logic [PW-1:0]       ptr, ptr_nxt, pick;
  logic signed [W-1:0] s1 [N];
  logic signed [W-1:0] s2 [N];
  logic signed [W-1:0] s1_nxt [N];
  logic signed [W-1:0] s2_nxt [N];
  logic signed [KW-1:0] key [N];
  logic signed [KW-1:0] best;
  logic                found, clip, v_over;
  logic [N-1:0]        sv_new;

  assign v_over = (v > VW'(N));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = (mode == 2'b00 && v != '0) ? SEARCH : UPDATE;
      SEARCH:  if (cnt + VW'(1) == v_lat) next_state = UPDATE;
      UPDATE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
  end

  // Selection key; the transition term biases elements toward keeping their previous state.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      key[i] = KW'(s1[i]);
      if (ORDER == 2) key[i] = key[i] + KW'(s2[i]);
`ifdef DEM_ISI_EN
      key[i] = sv[i] ? key[i] - KW'(ISI_W) : key[i] + KW'(ISI_W);
`endif
    end
  end

  // Smallest key among unmasked elements; strict compare keeps ties at the lowest index.
  always_comb begin
    found = 1'b0;
    best  = '0;
    pick  = '0;
    for (int i = 0; i < N; i++) begin
      if (!mask[i] && (!found || key[i] < best)) begin
        found = 1'b1;
        best  = key[i];
        pick  = PW'(i);
      end
    end
  end

  always_comb begin
    int off;
    int psum;
    sv_new = '0;
    off    = 0;
    psum   = int'(ptr) + int'(v_lat);
    ptr_nxt = (psum >= N) ? PW'(psum - N) : PW'(psum);
    for (int i = 0; i < N; i++) begin
      off = (i >= int'(ptr)) ? i - int'(ptr) : i + N - int'(ptr);
      case (mode_lat)
        2'b00:   sv_new[i] = mask[i];
        2'b01:   sv_new[i] = (off < int'(v_lat));
        default: sv_new[i] = (i < int'(v_lat));
      endcase
    end
  end

  always_comb begin
    logic signed [YW-1:0] y;
    logic signed [AW-1:0] t1;
    logic signed [AW-1:0] t2;
    clip = 1'b0;
    y    = '0;
    t1   = '0;
    t2   = '0;
    for (int i = 0; i < N; i++) begin
      y  = sv_new[i] ? YW'(N) - YW'(v_lat) : -YW'(v_lat);
      t1 = AW'(s1[i]) + AW'(y);
      if (t1 > SMAX) begin
        s1_nxt[i] = W'(SMAX);
        clip = 1'b1;
      end else if (t1 < SMIN) begin
        s1_nxt[i] = W'(SMIN);
        clip = 1'b1;
      end else begin
        s1_nxt[i] = W'(t1);
      end
      t2 = AW'(s2[i]) + AW'(s1_nxt[i]);
      if (ORDER != 2) begin
        s2_nxt[i] = s2[i];
      end else if (t2 > SMAX) begin
        s2_nxt[i] = W'(SMAX);
        clip = 1'b1;
      end else if (t2 < SMIN) begin
        s2_nxt[i] = W'(SMIN);
        clip = 1'b1;
      end else begin
        s2_nxt[i] = W'(t2);
      end
    end
  end

  // sv doubles as the previous-selection register for st and the transition key term.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_lat     <= '0;
      mode_lat  <= '0;
      sat_lat   <= 1'b0;
      mask      <= '0;
      cnt       <= '0;
      ptr       <= '0;
      sv        <= '0;
      st        <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
      for (int i = 0; i < N; i++) begin
        s1[i] <= '0;
        s2[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      sat       <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            v_lat    <= v_over ? VW'(N) : v;
            mode_lat <= mode;
            sat_lat  <= v_over;
            mask     <= '0;
            cnt      <= '0;
          end
        end
        SEARCH: begin
          mask <= mask | (N'(1) << pick);
          cnt  <= cnt + VW'(1);
        end
        UPDATE: begin
          sv        <= sv_new;
          st        <= sv_new ^ sv;
          out_valid <= 1'b1;
          sat       <= sat_lat | ((mode_lat == 2'b00) & clip);
          if (mode_lat == 2'b00) begin
            for (int i = 0; i < N; i++) begin
              s1[i] <= s1_nxt[i];
              s2[i] <= s2_nxt[i];
            end
          end
          if (mode_lat == 2'b01) ptr <= ptr_nxt;
        end
        default: ;
      endcase
    end
  end
endmodule
